v810_icache: RTL and testbench
==============================

// Module: v810_icache
// PURPOSE
// - Direct-mapped 1 KiB instruction cache between the instruction fetch unit (IF) and the memory access unit's IC port.
// - Hits return a word to IF in the same cycle. Misses fetch one 32-bit subblock over ICIA/ICID/ICIREQ/ICIACK and forward it.
// - Also provides bypass (cache disabled) and a sequential clear sweep.
// PARAMETERS
// - NUM_LINES  128  lines; 8-byte line = 2 x 4-byte subblocks; index = A[9:3], subblock = A[2], tag = A[31:10]
// - TAG_W      22   tag width; must equal 32-log2(NUM_LINES)-3
// PORTS
// - CLK     in   1   clock
// - RESn    in   1   reset, asynchronous, active-low
// - CE      in   1   global clock enable; qualifies every state update
// - IFA     in   32  fetch address; [1:0] ignored
// - IFREQ   in   1   fetch request; held with IFA stable until IFACK
// - IFD     out  32  fetch data; valid only when IFACK=1
// - IFACK   out  1   fetch acknowledge
// - ICE     in   1   cache enable (CHCW.ICE); 0 = bypass
// - ICLR    in   1   clear request; sampled as a level on a CE cycle
// - ICBUSY  out  1   clear sweep in progress
// - ICIA    out  32  memory address, {IFA[31:2],2'b00}
// - ICID    in   32  memory read data, valid with ICIACK
// - ICIREQ  out  1   memory request
// - ICIACK  in   1   memory acknowledge
// BEHAVIOUR
// - Storage is flops: data[NUM_LINES][2], tag[NUM_LINES], valid[NUM_LINES][2].
// - Async reset: all valid bits=0; state=IDLE; ICIREQ=0, IFACK=0, ICBUSY=0, clear counter=0. Data/tag arrays are not reset.
// - States: IDLE, FILL, BYP, CLEAR.
// - IDLE:
//   - ICLR=1 -> CLEAR. ICLR has priority over IFREQ in the same cycle.
//   - Otherwise, IFREQ & ICE & hit -> IFACK=1 and IFD=data, combinationally in the same cycle; stay in IDLE.
//     - hit = valid[idx][sb] & (tag[idx]==IFA[31:10]).
//   - IFREQ & ICE & miss -> FILL. IFREQ & ~ICE -> BYP.
// - FILL:
//   - ICIREQ=1 and ICIA driven until ICIACK.
//   - On ICIACK (CE cycle): IFD=ICID and IFACK=1 in the same cycle (forwarded); write data[idx][sb] and valid[idx][sb]=1.
//   - If the old tag differs, or the line had no valid subblock: tag[idx]<=new tag and valid[idx][~sb]<=0.
//   - Then -> IDLE, or -> CLEAR if a clear is pending.
// - BYP: as FILL, but no array write.
//   - ICE changing mid-access takes effect at the next IDLE decision.
// - CLEAR:
//   - ICBUSY=1; IFACK=0; ICIREQ=0.
//   - One line per CE cycle: valid[cnt]<=0, cnt++.
//   - After line NUM_LINES-1: cnt=0, then -> IDLE. Latency = NUM_LINES cycles.
//   - ICLR reasserted during CLEAR is ignored; the sweep is not restarted.
// - ICLR during FILL/BYP:
//   - Latched as pending.
//   - The in-flight access completes and its data is returned. The line is filled and later cleared by the sweep.
// - CE=0: no state, array or counter change. Combinational outputs still follow inputs.
// - IFREQ dropped before IFACK: protocol violation; no requirement. The bench asserts it never occurs.
// - Reset mid-FILL: ICIREQ drops asynchronously; the memory side must tolerate an abandoned request.
// - Back-to-back hits sustain 1 word/cycle. A miss costs 1 cycle (IDLE->FILL) plus memory latency.
// CONFIGURATION
// - V810_ICACHE_STATS_EN defined:
//   - Adds outputs HITCNT[31:0] and MISSCNT[31:0]; async reset to 0.
//   - HITCNT += 1 per hit IFACK; MISSCNT += 1 per FILL entry.
//   - Both wrap at 2^32; neither changes in bypass or CLEAR.
// - V810_ICACHE_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
// - Reset, ICE=1, fetch 0x0000_1000:
//   - miss -> ICIREQ with ICIA=0x0000_1000; ICID=0xDEAD_BEEF acked -> IFD=0xDEAD_BEEF, IFACK the same cycle.
//   - Refetch -> hit in 1 cycle, no ICIREQ.
// - Fill 0x1000 and 0x1004, then fetch 0x1400 (same index, tag 0x5):
//   - miss fills subblock 0, evicts the old subblock 1.
//   - Refetch 0x1004 -> miss, ICIA=0x0000_1004.
// - ICE=0, fetch 0x2000 twice -> two ICIREQ cycles; the later ICE=1 fetch of 0x2000 still misses.
// - Fill 4 lines, pulse ICLR -> ICBUSY high exactly 128 cycles, IFACK=0 throughout; afterwards all 4 addresses miss.
// - ICLR during FILL with ICIACK delayed 5 cycles:
//   - data is returned; CLEAR starts the next cycle.
//   - The filled address misses afterwards.
// - Hold CE=0 for 10 cycles mid-FILL:
//   - FILL persists and no arrays change.
//   - V810_ICACHE_STATS_EN: 3 hits + 2 misses -> HITCNT=3, MISSCNT=2.

Source files
------------

// File: rtl/v810_icache.sv
// v810_icache: direct-mapped instruction cache (2 x 32-bit subblocks per line) with bypass and clear sweep.
// Optional hit/miss statistics counters are enabled by defining V810_ICACHE_STATS_EN.
`default_nettype none

module v810_icache #(
    parameter int NUM_LINES = 128,
    parameter int TAG_W     = 22
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ce_i,
    input  logic [31:0] ifa_i,
    input  logic        ifreq_i,
    output logic [31:0] ifd_o,
    output logic        ifack_o,
    input  logic        ice_i,
    input  logic        iclr_i,
    output logic        icbusy_o,
    output logic [31:0] icia_o,
    input  logic [31:0] icid_i,
    output logic        icireq_o,
    input  logic        iciack_i
`ifdef V810_ICACHE_STATS_EN
    ,
    output logic [31:0] hitcnt_o,
    output logic [31:0] misscnt_o
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(NUM_LINES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_BYP   = 2'd2,
        S_CLEAR = 2'd3
    } state_e;

    state_e            state_q;
    logic              icireq_q;
    logic              icbusy_q;
    logic              clr_pend_q;
    logic [IDX_W-1:0]  cnt_q;

    logic [31:0]       data_q  [NUM_LINES][2];
    logic [TAG_W-1:0]  tag_q   [NUM_LINES];
    logic [1:0]        valid_q [NUM_LINES];

    logic [IDX_W-1:0]  w_idx;
    logic              w_sb;
    logic [TAG_W-1:0]  w_tag;
    logic              w_hit;
    logic              w_hit_ack;
    logic              w_miss_start;
    logic              w_mem_done;
    logic              w_fill_wr;
    logic              w_tag_new;
    logic              w_unused;

    assign w_idx = ifa_i[IDX_W+2:3];
    assign w_sb  = ifa_i[2];
    assign w_tag = ifa_i[31:IDX_W+3];

    assign w_hit        = valid_q[w_idx][w_sb] && (tag_q[w_idx] == w_tag);
    assign w_hit_ack    = (state_q == S_IDLE) && !iclr_i && ifreq_i && ice_i && w_hit;
    assign w_miss_start = (state_q == S_IDLE) && !iclr_i && ifreq_i && ice_i && !w_hit;
    assign w_mem_done   = ((state_q == S_FILL) || (state_q == S_BYP)) && iciack_i && ce_i;
    assign w_fill_wr    = (state_q == S_FILL) && iciack_i && ce_i;
    // A different tag, or an entirely empty line, means the line changes owner.
    assign w_tag_new    = (tag_q[w_idx] != w_tag) || (valid_q[w_idx] == 2'b00);

    assign ifack_o  = w_hit_ack || w_mem_done;
    assign ifd_o    = w_mem_done ? icid_i : data_q[w_idx][w_sb];
    assign icia_o   = {ifa_i[31:2], 2'b00};
    assign icireq_o = icireq_q;
    assign icbusy_o = icbusy_q;
    assign w_unused = ^ifa_i[1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            icireq_q   <= 1'b0;
            icbusy_q   <= 1'b0;
            clr_pend_q <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < NUM_LINES; i++) begin
                valid_q[i] <= 2'b00;
            end
        end else if (ce_i) begin
            case (state_q)
                S_IDLE: begin
                    if (iclr_i) begin
                        state_q  <= S_CLEAR;
                        icbusy_q <= 1'b1;
                    end else if (ifreq_i && !ice_i) begin
                        state_q  <= S_BYP;
                        icireq_q <= 1'b1;
                    end else if (w_miss_start) begin
                        state_q  <= S_FILL;
                        icireq_q <= 1'b1;
                    end
                end
                S_FILL, S_BYP: begin
                    if (iciack_i) begin
                        icireq_q <= 1'b0;
                        if (state_q == S_FILL) begin
                            valid_q[w_idx][w_sb] <= 1'b1;
                            if (w_tag_new) begin
                                valid_q[w_idx][~w_sb] <= 1'b0;
                            end
                        end
                        if (clr_pend_q || iclr_i) begin
                            state_q    <= S_CLEAR;
                            icbusy_q   <= 1'b1;
                            clr_pend_q <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else if (iclr_i) begin
                        clr_pend_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    valid_q[cnt_q] <= 2'b00;
                    if (cnt_q == LAST_LINE) begin
                        cnt_q    <= '0;
                        state_q  <= S_IDLE;
                        icbusy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + IDX_W'(1);
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    icireq_q <= 1'b0;
                    icbusy_q <= 1'b0;
                end
            endcase
        end
    end

    // Data and tag storage carries no reset; the valid bits alone decide hits.
    always_ff @(posedge clk_i) begin
        if (w_fill_wr) begin
            data_q[w_idx][w_sb] <= icid_i;
            if (w_tag_new) begin
                tag_q[w_idx] <= w_tag;
            end
        end
    end

`ifdef V810_ICACHE_STATS_EN
    logic [31:0] hitcnt_q;
    logic [31:0] misscnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hitcnt_q  <= '0;
            misscnt_q <= '0;
        end else if (ce_i) begin
            if (w_hit_ack) begin
                hitcnt_q <= hitcnt_q + 32'd1;
            end
            if (w_miss_start) begin
                misscnt_q <= misscnt_q + 32'd1;
            end
        end
    end

    assign hitcnt_o  = hitcnt_q;
    assign misscnt_o = misscnt_q;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_miss_start;
`endif

endmodule

`default_nettype wire

// File: tb/tb_v810_icache.sv
// tb_v810_icache: table-driven fetch vectors plus hand sequences for clear, CE stall and async reset.
`default_nettype none

module tb_v810_icache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [31:0] ifa;
    logic        ifreq;
    logic [31:0] ifd;
    logic        ifack;
    logic        ice;
    logic        iclr;
    logic        icbusy;
    logic [31:0] icia;
    logic [31:0] icid;
    logic        icireq;
    logic        iciack;
`ifdef V810_ICACHE_STATS_EN
    logic [31:0] hitcnt;
    logic [31:0] misscnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        logic        ice;
        logic [31:0] md;
        int          lat;
        bit          exp_miss;
        logic [31:0] exp_d;
    } vec_t;

    vec_t tbl[$];

    v810_icache dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .ce_i      (ce),
        .ifa_i     (ifa),
        .ifreq_i   (ifreq),
        .ifd_o     (ifd),
        .ifack_o   (ifack),
        .ice_i     (ice),
        .iclr_i    (iclr),
        .icbusy_o  (icbusy),
        .icia_o    (icia),
        .icid_i    (icid),
        .icireq_o  (icireq),
        .iciack_i  (iciack)
`ifdef V810_ICACHE_STATS_EN
        ,
        .hitcnt_o  (hitcnt),
        .misscnt_o (misscnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input logic [31:0] a, input logic ie, input logic [31:0] md,
                                 input int lat, input bit m, input logic [31:0] d);
        vec_t v;
        v.addr = a; v.ice = ie; v.md = md; v.lat = lat; v.exp_miss = m; v.exp_d = d;
        return v;
    endfunction

    // Holds IFREQ until IFACK; the memory side acks 'lat' cycles after ICIREQ rises.
    task automatic fetch(input logic [31:0] a, input logic [31:0] md, input int lat,
                         output logic [31:0] d, output bit miss, output logic [31:0] ia,
                         output int cyc, output bit ok);
        int req_cyc;
        req_cyc = 0; ok = 0; miss = 0; d = '0; ia = '0; cyc = 0;
        ifa = a;
        ifreq = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            icid   = md;
            iciack = icireq && (req_cyc >= lat);
            #3;
            if (icireq) begin
                miss = 1;
                ia   = icia;
                req_cyc++;
            end
            if (ifack) begin
                ok  = 1;
                d   = ifd;
                cyc = c + 1;
            end
            tick();
        end
        ifreq  = 1'b0;
        iciack = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] d, ia;
        bit miss, ok;
        int cyc;
        ice = v.ice;
        fetch(v.addr, v.md, v.lat, d, miss, ia, cyc, ok);
        chk($sformatf("ack %h", v.addr), 32'(ok), 32'd1);
        chk($sformatf("miss %h", v.addr), 32'(miss), 32'(v.exp_miss));
        chk($sformatf("data %h", v.addr), d, v.exp_d);
        chk($sformatf("cycles %h", v.addr), 32'(cyc), v.exp_miss ? 32'(v.lat + 2) : 32'd1);
        if (v.exp_miss) begin
            chk($sformatf("icia %h", v.addr), ia, {v.addr[31:2], 2'b00});
        end
    endtask

    initial begin
        logic [31:0] bad_md;
        int busy_cnt;
        bit saw_ack, bad;
        bad_md = 32'hBADB_AD00;

        rst_n = 1'b0; ce = 1'b1; ifa = '0; ifreq = 1'b0; ice = 1'b1;
        iclr = 1'b0; icid = '0; iciack = 1'b0;
        #2;
        chk("reset ifack", 32'(ifack), 32'd0);
        chk("reset icireq", 32'(icireq), 32'd0);
        chk("reset icbusy", 32'(icbusy), 32'd0);
`ifdef V810_ICACHE_STATS_EN
        chk("reset hitcnt", hitcnt, 32'd0);
        chk("reset misscnt", misscnt, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        tbl.push_back(mkv(32'h0000_8000, 1, 32'h8000_0000, 0, 1, 32'h8000_0000));
        tbl.push_back(mkv(32'h0000_8000, 1, bad_md,        0, 0, 32'h8000_0000));
        tbl.push_back(mkv(32'h0000_8004, 1, 32'h8004_0004, 1, 1, 32'h8004_0004));
        tbl.push_back(mkv(32'h0000_8004, 1, bad_md,        0, 0, 32'h8004_0004));
        tbl.push_back(mkv(32'h0000_8000, 1, bad_md,        0, 0, 32'h8000_0000));
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);
`ifdef V810_ICACHE_STATS_EN
        chk("hitcnt", hitcnt, 32'd3);
        chk("misscnt", misscnt, 32'd2);
`endif

        tbl.delete();
        tbl.push_back(mkv(32'h0000_1000, 1, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF));
        tbl.push_back(mkv(32'h0000_1000, 1, bad_md,        0, 0, 32'hDEAD_BEEF));
        tbl.push_back(mkv(32'h0000_1004, 1, 32'h1111_1111, 2, 1, 32'h1111_1111));
        tbl.push_back(mkv(32'h0000_1004, 1, bad_md,        0, 0, 32'h1111_1111));
        tbl.push_back(mkv(32'h0000_1000, 1, bad_md,        0, 0, 32'hDEAD_BEEF));
        tbl.push_back(mkv(32'h0000_1400, 1, 32'h2222_2222, 1, 1, 32'h2222_2222));
        tbl.push_back(mkv(32'h0000_1400, 1, bad_md,        0, 0, 32'h2222_2222));
        tbl.push_back(mkv(32'h0000_1004, 1, 32'h3333_3333, 0, 1, 32'h3333_3333));
        tbl.push_back(mkv(32'h0000_1000, 1, 32'h4444_4444, 0, 1, 32'h4444_4444));
        tbl.push_back(mkv(32'h0000_1004, 1, bad_md,        0, 0, 32'h3333_3333));
        tbl.push_back(mkv(32'h0000_2100, 0, 32'h5555_5555, 0, 1, 32'h5555_5555));
        tbl.push_back(mkv(32'h0000_2100, 0, 32'h6666_6666, 3, 1, 32'h6666_6666));
        tbl.push_back(mkv(32'h0000_2100, 1, 32'h7777_7777, 0, 1, 32'h7777_7777));
        tbl.push_back(mkv(32'h0000_2100, 1, bad_md,        0, 0, 32'h7777_7777));
        tbl.push_back(mkv(32'h0000_1004, 0, 32'h8888_8888, 0, 1, 32'h8888_8888));
        tbl.push_back(mkv(32'h0000_1004, 1, bad_md,        0, 0, 32'h3333_3333));
        tbl.push_back(mkv(32'h0000_3FFB, 1, 32'hAAAA_5555, 0, 1, 32'hAAAA_5555));
        tbl.push_back(mkv(32'h0000_3FF8, 1, bad_md,        0, 0, 32'hAAAA_5555));
        tbl.push_back(mkv(32'h0000_5008, 1, 32'h5A00_0001, 0, 1, 32'h5A00_0001));
        tbl.push_back(mkv(32'h0000_5010, 1, 32'h5A00_0002, 1, 1, 32'h5A00_0002));
        tbl.push_back(mkv(32'h0000_50F8, 1, 32'h5A00_0003, 0, 1, 32'h5A00_0003));
        tbl.push_back(mkv(32'h0000_53F8, 1, 32'h5A00_0004, 2, 1, 32'h5A00_0004));
        tbl.push_back(mkv(32'h0000_5010, 1, bad_md,        0, 0, 32'h5A00_0002));
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // ICLR with CE low must not start a sweep.
        ce = 1'b0; iclr = 1'b1;
        tick();
        ce = 1'b1; iclr = 1'b0;
        #3;
        chk("iclr ignored with ce=0", 32'(icbusy), 32'd0);
        tick();

        iclr = 1'b1;
        #3;
        chk("icbusy before sweep", 32'(icbusy), 32'd0);
        tick();
        iclr = 1'b0;
        busy_cnt = 0;
        saw_ack = 0;
        for (int c = 0; c < 300; c++) begin
            iclr = (c == 50);
            #3;
            if (!icbusy) break;
            busy_cnt++;
            if (ifack) saw_ack = 1;
            tick();
        end
        iclr = 1'b0;
        tick();
        chk("clear busy cycles", 32'(busy_cnt), 32'd128);
        chk("ifack during clear", 32'(saw_ack), 32'd0);

        tbl.delete();
        tbl.push_back(mkv(32'h0000_5008, 1, 32'h5B00_0001, 0, 1, 32'h5B00_0001));
        tbl.push_back(mkv(32'h0000_5010, 1, 32'h5B00_0002, 0, 1, 32'h5B00_0002));
        tbl.push_back(mkv(32'h0000_50F8, 1, 32'h5B00_0003, 0, 1, 32'h5B00_0003));
        tbl.push_back(mkv(32'h0000_53F8, 1, 32'h5B00_0004, 0, 1, 32'h5B00_0004));
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // ICLR during FILL, memory ack five cycles after the request.
        ice = 1'b1; ifa = 32'h0000_6000; ifreq = 1'b1;
        #3;
        chk("fill entry icireq", 32'(icireq), 32'd0);
        tick();
        iclr = 1'b1;
        #3;
        chk("fill icireq", 32'(icireq), 32'd1);
        tick();
        iclr = 1'b0;
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            #3;
            if (ifack || icbusy || !icireq) bad = 1;
            tick();
        end
        chk("pending clear wait", 32'(bad), 32'd0);
        iciack = 1'b1; icid = 32'hC0FF_EE00;
        #3;
        chk("pending clear ifack", 32'(ifack), 32'd1);
        chk("pending clear ifd", ifd, 32'hC0FF_EE00);
        tick();
        ifreq = 1'b0; iciack = 1'b0;
        #3;
        chk("clear after fill", 32'(icbusy), 32'd1);
        bad = 1;
        for (int c = 0; c < 200; c++) begin
            tick();
            #3;
            if (!icbusy) begin
                bad = 0;
                break;
            end
        end
        chk("clear after fill ends", 32'(bad), 32'd0);
        tick();
        run_vec(mkv(32'h0000_6000, 1, 32'h6100_0061, 0, 1, 32'h6100_0061));

        // CE held low for ten cycles while in FILL.
        run_vec(mkv(32'h0000_7000, 1, 32'h7000_0000, 0, 1, 32'h7000_0000));
        ice = 1'b1; ifa = 32'h0000_7004; ifreq = 1'b1;
        tick();
        ce = 1'b0; iciack = 1'b1; icid = bad_md;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            #3;
            if (ifack || !icireq) bad = 1;
            tick();
        end
        chk("ce stall in fill", 32'(bad), 32'd0);
        ce = 1'b1; icid = 32'h7004_0004;
        #3;
        chk("ce resume ifack", 32'(ifack), 32'd1);
        chk("ce resume ifd", ifd, 32'h7004_0004);
        tick();
        ifreq = 1'b0; iciack = 1'b0;
        run_vec(mkv(32'h0000_7000, 1, bad_md, 0, 0, 32'h7000_0000));
        run_vec(mkv(32'h0000_7004, 1, bad_md, 0, 0, 32'h7004_0004));

        // Asynchronous reset while a request is outstanding.
        ifa = 32'h0000_9000; ifreq = 1'b1;
        tick();
        #3;
        chk("pre-reset icireq", 32'(icireq), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset icireq", 32'(icireq), 32'd0);
        ifreq = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_vec(mkv(32'h0000_7000, 1, 32'h7A00_0000, 0, 1, 32'h7A00_0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
